// File: rtl/rmii_transmit_pkg.sv
// Shared types and constants for the RMII transmit framer and the matching receive path.
// Contains the byte-wide reflected CRC-32 step used by ethernet_crc32.
package rmii_transmit_pkg;

  typedef enum logic [2:0] {
    ST_IDLE     = 3'd0,
    ST_PREAMBLE = 3'd1,
    ST_SFD      = 3'd2,
    ST_DATA     = 3'd3,
    ST_PAD      = 3'd4,
    ST_FCS      = 3'd5,
    ST_GAP      = 3'd6
  } tx_state_t;

  localparam logic [7:0]  PREAMBLE_BYTE   = 8'h55;
  localparam logic [7:0]  SFD_BYTE        = 8'hD5;
  localparam logic [31:0] CRC32_POLY      = 32'hEDB88320;
  localparam logic [31:0] CRC32_INIT      = 32'hFFFFFFFF;
  localparam int          PREAMBLE_DIBITS = 28;

  // LSB-first CRC-32 over one byte, matching wire bit order.
  function automatic logic [31:0] crc32_byte(input logic [31:0] crc, input logic [7:0] data);
    logic [31:0] c;
    c = crc;
    for (int i = 0; i < 8; i++) begin
      c = (c >> 1) ^ ((c[0] ^ data[i]) ? CRC32_POLY : 32'h0);
    end
    return c;
  endfunction

endpackage

// File: rtl/ethernet_crc32.sv
// Byte-wide Ethernet CRC-32 accumulator with synchronous clear; shared by TX and RX paths.
module ethernet_crc32
  import rmii_transmit_pkg::*;
(
  input  logic        clock,
  input  logic        reset,
  input  logic        clear,
  input  logic        enable,
  input  logic [7:0]  data,
  output logic [31:0] crc
);

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      crc <= CRC32_INIT;
    end else if (clear) begin
      crc <= CRC32_INIT;
    end else if (enable) begin
      crc <= crc32_byte(crc, data);
    end
  end

endmodule

// File: rtl/rmii_transmit_framer.sv
// RMII transmit framer: preamble/SFD, byte stream, zero padding, optional FCS, then gap.
// Define RMII_TRANSMIT_FCS_EN to append the CRC-32 FCS; otherwise the core supplies it.
module rmii_transmit_framer
  import rmii_transmit_pkg::*;
#(
  parameter int MINIMUM_FRAME_BYTES    = 60,
  parameter int INTER_PACKET_GAP_BYTES = 12
) (
  input  logic       clock,
  input  logic       reset,
  input  logic [8:0] transmit_data,
  input  logic       transmit_data_enable,
  output logic       transmit_data_ready,
  output logic [1:0] rmii_transmit_data,
  output logic       rmii_transmit_data_valid,
  output logic       transmit_busy,
  output logic       transmit_underrun,
  output logic [2:0] debug_state
);

  // Handshake: a byte moves when transmit_data_ready and transmit_data_enable are both high
  // on a rising clock edge; enable must be held with stable data until that edge.
  localparam int GAP_CLOCKS = 4 * INTER_PACKET_GAP_BYTES;
  localparam int CNT_MAX    = (GAP_CLOCKS > PREAMBLE_DIBITS) ? GAP_CLOCKS : PREAMBLE_DIBITS;
  localparam int CNT_W      = $clog2(CNT_MAX + 1);
  localparam logic [CNT_W-1:0] PRE_LAST  = CNT_W'(PREAMBLE_DIBITS - 1);
  localparam logic [CNT_W-1:0] BYTE_LAST = CNT_W'(3);
  localparam logic [CNT_W-1:0] FCS_LAST  = CNT_W'(15);
  localparam logic [CNT_W-1:0] GAP_LAST  = CNT_W'(GAP_CLOCKS - 1);
`ifdef RMII_TRANSMIT_FCS_EN
  localparam tx_state_t BODY_DONE = ST_FCS;
`else
  localparam tx_state_t BODY_DONE = ST_GAP;
`endif

  tx_state_t        state, state_n;
  logic [CNT_W-1:0] cnt, cnt_n;
  logic [7:0]       shift, shift_n;
  logic             last, last_n;
  logic [10:0]      byte_cnt;
  logic             take, pad_load, starve, frame_start, pad_needed;
  logic             valid_n, ready_n;
  logic [1:0]       dibit_n;

  assign take       = transmit_data_ready & transmit_data_enable;
  assign pad_needed = int'(byte_cnt) < MINIMUM_FRAME_BYTES;
  assign shift_n    = take ? transmit_data[7:0] : (pad_load ? 8'h00 : shift);
  assign last_n     = take ? transmit_data[8] : last;
  assign debug_state = state;

`ifdef RMII_TRANSMIT_FCS_EN
  logic [31:0] crc;
  logic [31:0] fcs;

  ethernet_crc32 u_crc (
    .clock  (clock),
    .reset  (reset),
    .clear  (frame_start),
    .enable (take | pad_load),
    .data   (take ? transmit_data[7:0] : 8'h00),
    .crc    (crc)
  );
  assign fcs = ~crc;
`endif

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state                    <= ST_IDLE;
      cnt                      <= '0;
      shift                    <= '0;
      last                     <= 1'b0;
      byte_cnt                 <= '0;
      transmit_data_ready      <= 1'b0;
      rmii_transmit_data       <= 2'b00;
      rmii_transmit_data_valid <= 1'b0;
      transmit_busy            <= 1'b0;
      transmit_underrun        <= 1'b0;
    end else begin
      state <= state_n;
      cnt   <= cnt_n;
      shift <= shift_n;
      last  <= last_n;
      if (frame_start) begin
        byte_cnt <= '0;
      end else if ((take || pad_load) && byte_cnt != 11'h7FF) begin
        byte_cnt <= byte_cnt + 11'd1;
      end
      transmit_data_ready      <= ready_n;
      rmii_transmit_data       <= dibit_n;
      rmii_transmit_data_valid <= valid_n;
      transmit_busy            <= (state_n != ST_IDLE);
      transmit_underrun        <= starve;
    end
  end

  always_comb begin
    state_n     = state;
    cnt_n       = cnt + 1'b1;
    pad_load    = 1'b0;
    starve      = 1'b0;
    frame_start = 1'b0;
    case (state)
      ST_IDLE: begin
        cnt_n = '0;
        if (transmit_data_enable) begin
          state_n     = ST_PREAMBLE;
          frame_start = 1'b1;
        end
      end
      ST_PREAMBLE: begin
        if (cnt == PRE_LAST) begin
          state_n = ST_SFD;
          cnt_n   = '0;
        end
      end
      // Byte boundary: fetch the next byte, pad, or finish the body.
      ST_SFD, ST_DATA, ST_PAD: begin
        if (cnt == BYTE_LAST) begin
          cnt_n = '0;
          if (transmit_data_ready) begin
            if (transmit_data_enable) begin
              state_n = ST_DATA;
            end else begin
              state_n = ST_GAP;
              starve  = 1'b1;
            end
          end else if (pad_needed) begin
            state_n  = ST_PAD;
            pad_load = 1'b1;
          end else begin
            state_n = BODY_DONE;
          end
        end
      end
      ST_FCS: begin
        if (cnt == FCS_LAST) begin
          state_n = ST_GAP;
          cnt_n   = '0;
        end
      end
      // The idle check for a waiting frame is folded into the last gap clock,
      // so back-to-back frames are spaced by exactly the gap.
      ST_GAP: begin
        if (cnt == GAP_LAST) begin
          cnt_n = '0;
          if (transmit_data_enable) begin
            state_n     = ST_PREAMBLE;
            frame_start = 1'b1;
          end else begin
            state_n = ST_IDLE;
          end
        end
      end
      default: begin
        state_n = ST_IDLE;
        cnt_n   = '0;
      end
    endcase
  end

  always_comb begin
    valid_n = 1'b0;
    dibit_n = 2'b00;
    ready_n = 1'b0;
    case (state_n)
      ST_PREAMBLE: begin
        valid_n = 1'b1;
        dibit_n = PREAMBLE_BYTE[{cnt_n[1:0], 1'b0} +: 2];
      end
      ST_SFD: begin
        valid_n = 1'b1;
        dibit_n = SFD_BYTE[{cnt_n[1:0], 1'b0} +: 2];
        ready_n = (cnt_n == BYTE_LAST);
      end
      ST_DATA: begin
        valid_n = 1'b1;
        dibit_n = shift_n[{cnt_n[1:0], 1'b0} +: 2];
        ready_n = (cnt_n == BYTE_LAST) && !last_n;
      end
      ST_PAD: begin
        valid_n = 1'b1;
      end
`ifdef RMII_TRANSMIT_FCS_EN
      ST_FCS: begin
        valid_n = 1'b1;
        dibit_n = fcs[{cnt_n[3:0], 1'b0} +: 2];
      end
`endif
      default: begin
        valid_n = 1'b0;
      end
    endcase
  end

endmodule

// File: tb/tb_rmii_transmit_framer.sv
// Directed bench for rmii_transmit_framer: a padding instance (60) and a non-padding instance (0).
// Expected dibit streams are built from hand constants plus a bitwise CRC-32 reference.
module tb_rmii_transmit_framer;

`ifdef RMII_TRANSMIT_FCS_EN
  localparam bit FCS_ON = 1'b1;
`else
  localparam bit FCS_ON = 1'b0;
`endif

  // clock / reset
  logic clock  = 1'b0;
  logic reset  = 1'b1;
  logic [8:0] data = '0;
  logic enable = 1'b0;
  logic sel    = 1'b0;
  int   cyc    = 0;

  always #10 clock = ~clock;
  always @(posedge clock) cyc <= cyc + 1;

  logic       en_a, en_b, ready_a, ready_b, valid_a, valid_b, busy_a, busy_b, und_a, und_b;
  logic [1:0] dibit_a, dibit_b;
  logic [2:0] dbg_a, dbg_b;
  logic       ready, valid, busy, underrun;
  logic [1:0] dibit;

  assign en_a     = enable & ~sel;
  assign en_b     = enable & sel;
  assign ready    = sel ? ready_b : ready_a;
  assign valid    = sel ? valid_b : valid_a;
  assign busy     = sel ? busy_b  : busy_a;
  assign underrun = sel ? und_b   : und_a;
  assign dibit    = sel ? dibit_b : dibit_a;

  rmii_transmit_framer #(.MINIMUM_FRAME_BYTES(60), .INTER_PACKET_GAP_BYTES(12)) dut_pad (
    .clock(clock), .reset(reset), .transmit_data(data), .transmit_data_enable(en_a),
    .transmit_data_ready(ready_a), .rmii_transmit_data(dibit_a), .rmii_transmit_data_valid(valid_a),
    .transmit_busy(busy_a), .transmit_underrun(und_a), .debug_state(dbg_a)
  );

  rmii_transmit_framer #(.MINIMUM_FRAME_BYTES(0), .INTER_PACKET_GAP_BYTES(12)) dut_nopad (
    .clock(clock), .reset(reset), .transmit_data(data), .transmit_data_enable(en_b),
    .transmit_data_ready(ready_b), .rmii_transmit_data(dibit_b), .rmii_transmit_data_valid(valid_b),
    .transmit_busy(busy_b), .transmit_underrun(und_b), .debug_state(dbg_b)
  );

  // scoreboard state
  typedef struct packed {logic valid; logic [1:0] dibit; logic busy; logic underrun;} rec_t;
  rec_t       log_q[$];
  int         log_cyc[$];
  bit         logging = 1'b0;
  logic [1:0] exp_q[$];
  logic [8:0] tx_q[$];
  logic [7:0] pay_q[$];
  int         n_checks = 0;
  int         n_errors = 0;
  int         t_en = 0;
  int         g_fi = 0;
  int         g_len = 0;

  always @(negedge clock) begin
    if (logging) begin
      log_q.push_back('{valid, dibit, busy, underrun});
      log_cyc.push_back(cyc);
    end
  end

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", tag, got, got, exp, exp);
    end
  endtask

  function automatic logic [31:0] crc_step(input logic [31:0] c, input logic [7:0] b);
    logic [31:0] r;
    r = c;
    for (int k = 0; k < 8; k++) begin
      if (r[0] ^ b[k]) r = (r >> 1) ^ 32'hEDB88320;
      else r = r >> 1;
    end
    return r;
  endfunction

  task automatic push_byte(input logic [7:0] b);
    for (int k = 0; k < 4; k++) exp_q.push_back(b[2*k +: 2]);
  endtask

  // Pops n_bytes of payload; pads to min_bytes and appends FCS when requested.
  task automatic build_frame(input int n_bytes, input int min_bytes, input bit with_fcs);
    logic [31:0] c;
    logic [7:0]  b;
    int          n;
    c = 32'hFFFFFFFF;
    exp_q.delete();
    for (int i = 0; i < 28; i++) exp_q.push_back(2'b01);
    exp_q.push_back(2'b01); exp_q.push_back(2'b01); exp_q.push_back(2'b01); exp_q.push_back(2'b11);
    for (int i = 0; i < n_bytes; i++) begin
      b = pay_q.pop_front();
      push_byte(b);
      c = crc_step(c, b);
    end
    n = n_bytes;
    while (n < min_bytes) begin
      push_byte(8'h00);
      c = crc_step(c, 8'h00);
      n++;
    end
    if (with_fcs && FCS_ON) begin
      c = ~c;
      for (int i = 0; i < 4; i++) push_byte(c[8*i +: 8]);
    end
  endtask

  task automatic load_frame(input int n, input logic [7:0] seed, input logic [7:0] step);
    logic [7:0] b;
    for (int i = 0; i < n; i++) begin
      b = seed + 8'(i) * step;
      tx_q.push_back({(i == n - 1), b});
      pay_q.push_back(b);
    end
  endtask

  // driver: presents tx_q bytes, advancing after each accepted handshake
  task automatic drive_stream(input int drop_at);
    int idx;
    int budget;
    idx = 0;
    budget = 20000;
    @(negedge clock);
    if (tx_q.size() == 0) return;
    data = tx_q.pop_front();
    enable = 1'b1;
    t_en = cyc;
    while (budget > 0) begin
      @(negedge clock);
      budget--;
      if (reset) break;
      if (ready) begin
        if (idx == drop_at) break;
        @(posedge clock);
        #1;
        idx++;
        if (tx_q.size() == 0) break;
        data = tx_q.pop_front();
      end
    end
    enable = 1'b0;
    data = '0;
    if (budget == 0) check_eq("drive_budget", 32'd1, 32'd0);
  endtask

  task automatic wait_idle(input string tag);
    int n;
    n = 0;
    while ((busy || enable) && n < 5000) begin
      @(negedge clock);
      n++;
    end
    check_eq({tag, "_idle"}, 32'(n < 5000), 32'd1);
    repeat (4) @(negedge clock);
  endtask

  task automatic run_frames(input string tag, input int drop_at);
    log_q.delete();
    log_cyc.delete();
    logging = 1'b1;
    drive_stream(drop_at);
    wait_idle(tag);
    logging = 1'b0;
  endtask

  function automatic int first_valid(input int from);
    for (int i = from; i < log_q.size(); i++) if (log_q[i].valid) return i;
    return -1;
  endfunction

  function automatic int run_len(input int from);
    int n;
    n = 0;
    while (from + n < log_q.size() && log_q[from + n].valid) n++;
    return n;
  endfunction

  function automatic int gap_len(input int from);
    int n;
    n = 0;
    while (from + n < log_q.size() && !log_q[from + n].valid && log_q[from + n].busy) n++;
    return n;
  endfunction

  function automatic int idle_data_errors();
    int n;
    n = 0;
    for (int i = 0; i < log_q.size(); i++) if (!log_q[i].valid && log_q[i].dibit != 2'b00) n++;
    return n;
  endfunction

  function automatic int underrun_count();
    int n;
    n = 0;
    for (int i = 0; i < log_q.size(); i++) if (log_q[i].underrun) n++;
    return n;
  endfunction

  task automatic score_frame(input string tag, input int from);
    int mism;
    int n_exp;
    g_fi = first_valid(from);
    check_eq({tag, "_found"}, 32'(g_fi >= 0), 32'd1);
    if (g_fi < 0) begin
      g_fi = log_q.size();
      g_len = 0;
      exp_q.delete();
      return;
    end
    g_len = run_len(g_fi);
    n_exp = exp_q.size();
    check_eq({tag, "_len_vs_model"}, 32'(g_len), 32'(n_exp));
    mism = 0;
    for (int j = 0; j < g_len; j++) begin
      if (exp_q.size() == 0) break;
      if (log_q[g_fi + j].dibit !== exp_q.pop_front()) mism++;
    end
    check_eq({tag, "_dibit_errors"}, 32'(mism), 32'd0);
    exp_q.delete();
  endtask

  initial begin
    int end1;
    int fi2;

    // reset state
    repeat (3) @(posedge clock);
    @(negedge clock);
    check_eq("rst_valid", 32'(valid_a), 32'd0);
    check_eq("rst_data", 32'(dibit_a), 32'd0);
    check_eq("rst_ready", 32'(ready_a), 32'd0);
    check_eq("rst_busy", 32'(busy_a), 32'd0);
    check_eq("rst_underrun", 32'(und_a), 32'd0);
    check_eq("rst_state", 32'(dbg_a), 32'd0);
    reset = 1'b0;
    repeat (2) @(negedge clock);

    // 1-byte frame padded to 60 bytes
    sel = 1'b0;
    load_frame(1, 8'hAB, 8'h00);
    run_frames("t1", -1);
    build_frame(1, 60, 1'b1);
    score_frame("t1", 0);
    check_eq("t1_len", 32'(g_len), FCS_ON ? 32'd288 : 32'd272);
    check_eq("t1_latency", 32'(log_cyc[g_fi]), 32'(t_en + 1));
    check_eq("t1_gap", 32'(gap_len(g_fi + g_len)), 32'd48);
    check_eq("t1_underrun", 32'(underrun_count()), 32'd0);
    check_eq("t1_idle_data", 32'(idle_data_errors()), 32'd0);

    // 9-byte "123456789" frame without padding; FCS bytes 26 39 F4 CB
    sel = 1'b1;
    load_frame(9, 8'h31, 8'h01);
    run_frames("t2", -1);
    build_frame(9, 0, 1'b0);
    if (FCS_ON) begin
      push_byte(8'h26); push_byte(8'h39); push_byte(8'hF4); push_byte(8'hCB);
    end
    score_frame("t2", 0);
    check_eq("t2_len", 32'(g_len), FCS_ON ? 32'd84 : 32'd68);
    check_eq("t2_gap", 32'(gap_len(g_fi + g_len)), 32'd48);
    sel = 1'b0;
    repeat (2) @(negedge clock);

    // underrun at byte index 10
    load_frame(20, 8'h03, 8'h07);
    run_frames("t3", 10);
    tx_q.delete();
    build_frame(10, 0, 1'b0);
    pay_q.delete();
    score_frame("t3", 0);
    check_eq("t3_len", 32'(g_len), 32'd72);
    check_eq("t3_underrun_cnt", 32'(underrun_count()), 32'd1);
    check_eq("t3_underrun_pos", 32'(log_q[g_fi + g_len].underrun), 32'd1);
    check_eq("t3_gap", 32'(gap_len(g_fi + g_len)), 32'd48);

    // two 64-byte frames back to back
    load_frame(64, 8'h10, 8'h03);
    load_frame(64, 8'hF0, 8'h05);
    run_frames("t4", -1);
    build_frame(64, 60, 1'b1);
    score_frame("t4a", 0);
    check_eq("t4a_len", 32'(g_len), FCS_ON ? 32'd304 : 32'd288);
    end1 = g_fi + g_len;
    check_eq("t4_gap", 32'(gap_len(end1)), 32'd48);
    build_frame(64, 60, 1'b1);
    score_frame("t4b", end1);
    fi2 = g_fi;
    check_eq("t4_spacing", 32'(fi2 - (end1 - 1)), 32'd49);
    check_eq("t4b_len", 32'(g_len), FCS_ON ? 32'd304 : 32'd288);

    // asynchronous reset in the middle of DATA
    load_frame(30, 8'h40, 8'h01);
    fork
      drive_stream(-1);
      begin
        repeat (60) @(posedge clock);
        #3;
        check_eq("t5_pre_state", 32'(dbg_a), 32'd3);
        reset = 1'b1;
        #1;
        check_eq("t5_valid", 32'(valid_a), 32'd0);
        check_eq("t5_data", 32'(dibit_a), 32'd0);
        check_eq("t5_busy", 32'(busy_a), 32'd0);
        check_eq("t5_ready", 32'(ready_a), 32'd0);
        check_eq("t5_state", 32'(dbg_a), 32'd0);
      end
    join
    tx_q.delete();
    pay_q.delete();
    repeat (2) @(negedge clock);
    reset = 1'b0;
    repeat (2) @(negedge clock);
    load_frame(9, 8'h31, 8'h01);
    run_frames("t5", -1);
    build_frame(9, 60, 1'b1);
    score_frame("t5", 0);
    check_eq("t5_len", 32'(g_len), FCS_ON ? 32'd288 : 32'd272);
    check_eq("t5_idle_data", 32'(idle_data_errors()), 32'd0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

  initial begin
    #5000000;
    $display("FAIL watchdog: simulation time limit reached after %0d checks", n_checks);
    $fatal(1, "watchdog");
  end

endmodule
